imsic_msi_rx: RTL and testbench



---
 rtl/imsic_msi_pkg.sv | 82 ++++++++
 rtl/imsic_msi_rx_if.sv | 11 +
 rtl/imsic_msi_decode.sv | 67 ++++++
 rtl/imsic_msi_rx.sv | 227 ++++++++++++++++++++++
 tb/tb_imsic_msi_rx.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/imsic_msi_pkg.sv
// Shared types and constants for the IMSIC MSI write responder.
// MSI_BE_EN (optional): also accept the big-endian seteipnum register.
package imsic_msi_pkg;

  localparam int unsigned AXI_ADDR_W = 32;
  localparam int unsigned AXI_DATA_W = 64;  // XLEN
  localparam int unsigned AXI_ID_W   = 4;

  localparam logic [11:0] SETEIPNUM_LE_OFF = 12'h000;
  localparam logic [11:0] SETEIPNUM_BE_OFF = 12'h004;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    W_IDLE,
    W_DATA,
    W_NOTIFY,
    W_RESP
  } w_state_e;

  typedef enum logic {
    R_IDLE,
    R_BEAT
  } r_state_e;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_ADDR_W-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
  } axi_aw_t;

  typedef struct packed {
    logic [AXI_DATA_W-1:0] data;
    logic                  last;
  } axi_w_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [7:0]          len;
  } axi_ar_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0] id;
    logic [1:0]          resp;
  } axi_b_t;

  typedef struct packed {
    logic [AXI_ID_W-1:0]   id;
    logic [AXI_DATA_W-1:0] data;
    logic [1:0]            resp;
    logic                  last;
  } axi_r_t;

  typedef struct packed {
    axi_aw_t aw;
    logic    aw_valid;
    axi_w_t  w;
    logic    w_valid;
    logic    b_ready;
    axi_ar_t ar;
    logic    ar_valid;
    logic    r_ready;
  } axi_req_t;

  typedef struct packed {
    logic   aw_ready;
    logic   w_ready;
    logic   ar_ready;
    axi_b_t b;
    logic   b_valid;
    axi_r_t r;
    logic   r_valid;
  } axi_rsp_t;

  // Index width that never collapses to zero bits.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/imsic_msi_rx_if.sv
// AXI request/response bundle between an MSI initiator and imsic_msi_rx.
interface imsic_msi_rx_if;
  import imsic_msi_pkg::*;

  axi_req_t req;
  axi_rsp_t rsp;

  modport master (output req, input rsp);
  modport slave  (input req, output rsp);

endinterface

// File: rtl/imsic_msi_decode.sv
// Combinational MSI target decode: IMSIC/file/register, lane select, EIID.
// MSI_BE_EN (optional): offset 0x004 is valid and its data is byte-swapped.
module imsic_msi_decode
  import imsic_msi_pkg::*;
#(
  parameter int unsigned           NR_SRC        = 64,
  parameter int unsigned           NR_IMSICS     = 4,
  parameter int unsigned           NR_INTP_FILES = 3,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR     = 32'h2400_0000,
  parameter logic [AXI_ADDR_W-1:0] IMSIC_STRIDE  = 32'h0000_4000
) (
  input  logic [AXI_ADDR_W-1:0]                   addr_i,
  input  logic [2:0]                              size_i,
  input  logic [7:0]                              len_i,
  input  logic [AXI_DATA_W-1:0]                   wdata_i,
  output logic                                    target_valid_c_o,
  output logic                                    notify_c_o,
  output logic [clog2_min1(NR_IMSICS)-1:0]        imsic_c_o,
  output logic [clog2_min1(NR_INTP_FILES)-1:0]    file_c_o,
  output logic [clog2_min1(NR_SRC)-1:0]           eiid_c_o
);

  localparam int unsigned IMSIC_W      = clog2_min1(NR_IMSICS);
  localparam int unsigned FILE_W       = clog2_min1(NR_INTP_FILES);
  localparam int unsigned EIID_W       = clog2_min1(NR_SRC);
  localparam int unsigned STRIDE_SHIFT = $clog2(IMSIC_STRIDE);

  logic [AXI_ADDR_W-1:0] off;
  logic [AXI_ADDR_W-1:0] imsic_idx;
  logic [AXI_ADDR_W-1:0] file_idx;
  logic [11:0]           reg_off;
  logic [31:0]           word;
  logic [31:0]           eiid_word;
  logic                  below_base;
  logic                  reg_ok;
  logic                  be_sel;

  // Split the offset into IMSIC / file / register and pick the 32-bit lane.
  always_comb begin
    off        = addr_i - BASE_ADDR;
    below_base = (addr_i < BASE_ADDR);
    imsic_idx  = off >> STRIDE_SHIFT;
    file_idx   = (off & (IMSIC_STRIDE - 32'd1)) >> 12;
    reg_off    = off[11:0];
    word       = addr_i[2] ? wdata_i[32 +: 32] : wdata_i[0 +: 32];
`ifdef MSI_BE_EN
    be_sel     = (reg_off == SETEIPNUM_BE_OFF);
    reg_ok     = (reg_off == SETEIPNUM_LE_OFF) || be_sel;
`else
    be_sel     = 1'b0;
    reg_ok     = (reg_off == SETEIPNUM_LE_OFF);
`endif
    eiid_word  = be_sel ? {word[7:0], word[15:8], word[23:16], word[31:24]} : word;

    target_valid_c_o = !below_base
                     && (imsic_idx < AXI_ADDR_W'(NR_IMSICS))
                     && (file_idx < AXI_ADDR_W'(NR_INTP_FILES))
                     && reg_ok
                     && (size_i == 3'd2)
                     && (len_i == 8'd0);
    notify_c_o = target_valid_c_o && (eiid_word != 32'd0) && (eiid_word < 32'(NR_SRC));
    imsic_c_o  = imsic_idx[IMSIC_W-1:0];
    file_c_o   = file_idx[FILE_W-1:0];
    eiid_c_o   = eiid_word[EIID_W-1:0];
  end

endmodule

// File: rtl/imsic_msi_rx.sv
// AXI4 responder terminating MSI writes to IMSIC seteipnum registers and
// turning them into a valid/ready set-pending request; reads return zero.
// MSI_BE_EN (optional): accept seteipnum_be at offset 0x004.
module imsic_msi_rx
  import imsic_msi_pkg::*;
#(
  parameter int unsigned           NR_SRC                = 64,
  parameter int unsigned           NR_IMSICS             = 4,
  parameter int unsigned           NR_VS_FILES_PER_IMSIC = 1,
  parameter int unsigned           NR_INTP_FILES         = 2 + NR_VS_FILES_PER_IMSIC,
  parameter logic [AXI_ADDR_W-1:0] BASE_ADDR             = 32'h2400_0000,
  parameter logic [AXI_ADDR_W-1:0] IMSIC_STRIDE          = 32'h0000_4000
) (
  input  logic                                 i_clk,
  input  logic                                 ni_rst,
  input  axi_req_t                             i_req,
  output axi_rsp_t                             o_resp,
  output logic                                 o_setipnum_valid,
  input  logic                                 i_setipnum_ready,
  output logic [clog2_min1(NR_IMSICS)-1:0]     o_setipnum_imsic,
  output logic [clog2_min1(NR_INTP_FILES)-1:0] o_setipnum_file,
  output logic [clog2_min1(NR_SRC)-1:0]        o_setipnum_eiid
);

  localparam int unsigned IMSIC_W = clog2_min1(NR_IMSICS);
  localparam int unsigned FILE_W  = clog2_min1(NR_INTP_FILES);
  localparam int unsigned EIID_W  = clog2_min1(NR_SRC);

  w_state_e            w_state_q, w_state_d;
  axi_aw_t             aw_q, aw_d;
  logic                werr_q, werr_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                awready_q, awready_d;
  logic                wready_q, wready_d;
  logic                bvalid_q, bvalid_d;
  logic                sip_valid_q, sip_valid_d;
  logic [IMSIC_W-1:0]  sip_imsic_q, sip_imsic_d;
  logic [FILE_W-1:0]   sip_file_q, sip_file_d;
  logic [EIID_W-1:0]   sip_eiid_q, sip_eiid_d;

  r_state_e            r_state_q, r_state_d;
  logic [AXI_ID_W-1:0] arid_q, arid_d;
  logic [7:0]          rcnt_q, rcnt_d;
  logic                arready_q, arready_d;
  logic                rvalid_q, rvalid_d;
  logic                rlast_q, rlast_d;

  logic                dec_target_valid;
  logic                dec_notify;
  logic [IMSIC_W-1:0]  dec_imsic;
  logic [FILE_W-1:0]   dec_file;
  logic [EIID_W-1:0]   dec_eiid;

  logic aw_hs, w_hs, b_hs, sip_hs, ar_hs, r_hs;

  assign aw_hs  = i_req.aw_valid & awready_q;
  assign w_hs   = i_req.w_valid & wready_q;
  assign b_hs   = i_req.b_ready & bvalid_q;
  assign sip_hs = i_setipnum_ready & sip_valid_q;
  assign ar_hs  = i_req.ar_valid & arready_q;
  assign r_hs   = i_req.r_ready & rvalid_q;

  // Decode the captured AW against the live W beat.
  imsic_msi_decode #(
    .NR_SRC        (NR_SRC),
    .NR_IMSICS     (NR_IMSICS),
    .NR_INTP_FILES (NR_INTP_FILES),
    .BASE_ADDR     (BASE_ADDR),
    .IMSIC_STRIDE  (IMSIC_STRIDE)
  ) u_decode (
    .addr_i           (aw_q.addr),
    .size_i           (aw_q.size),
    .len_i            (aw_q.len),
    .wdata_i          (i_req.w.data),
    .target_valid_c_o (dec_target_valid),
    .notify_c_o       (dec_notify),
    .imsic_c_o        (dec_imsic),
    .file_c_o         (dec_file),
    .eiid_c_o         (dec_eiid)
  );

  // Write FSM next state; handshake outputs are registered from the next state.
  always_comb begin
    w_state_d   = w_state_q;
    aw_d        = aw_q;
    werr_d      = werr_q;
    bresp_d     = bresp_q;
    sip_imsic_d = sip_imsic_q;
    sip_file_d  = sip_file_q;
    sip_eiid_d  = sip_eiid_q;
    unique case (w_state_q)
      W_IDLE: begin
        if (aw_hs) begin
          aw_d      = i_req.aw;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        if (w_hs) begin
          if (!i_req.w.last) begin
            werr_d = 1'b1;
          end else if (werr_q || !dec_target_valid) begin
            bresp_d   = RESP_SLVERR;
            w_state_d = W_RESP;
          end else if (dec_notify) begin
            bresp_d     = RESP_OKAY;
            sip_imsic_d = dec_imsic;
            sip_file_d  = dec_file;
            sip_eiid_d  = dec_eiid;
            w_state_d   = W_NOTIFY;
          end else begin
            bresp_d   = RESP_OKAY;
            w_state_d = W_RESP;
          end
        end
      end
      W_NOTIFY: begin
        if (sip_hs) w_state_d = W_RESP;
      end
      W_RESP: begin
        if (b_hs) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
    awready_d   = (w_state_d == W_IDLE);
    wready_d    = (w_state_d == W_DATA);
    sip_valid_d = (w_state_d == W_NOTIFY);
    bvalid_d    = (w_state_d == W_RESP);
  end

  // Write FSM registers.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      w_state_q   <= W_IDLE;
      aw_q        <= '0;
      werr_q      <= 1'b0;
      bresp_q     <= RESP_OKAY;
      awready_q   <= 1'b0;
      wready_q    <= 1'b0;
      bvalid_q    <= 1'b0;
      sip_valid_q <= 1'b0;
      sip_imsic_q <= '0;
      sip_file_q  <= '0;
      sip_eiid_q  <= '0;
    end else begin
      w_state_q   <= w_state_d;
      aw_q        <= aw_d;
      werr_q      <= werr_d;
      bresp_q     <= bresp_d;
      awready_q   <= awready_d;
      wready_q    <= wready_d;
      bvalid_q    <= bvalid_d;
      sip_valid_q <= sip_valid_d;
      sip_imsic_q <= sip_imsic_d;
      sip_file_q  <= sip_file_d;
      sip_eiid_q  <= sip_eiid_d;
    end
  end

  // Read FSM next state: arlen+1 zero beats, rlast on the final one.
  always_comb begin
    r_state_d = r_state_q;
    arid_d    = arid_q;
    rcnt_d    = rcnt_q;
    unique case (r_state_q)
      R_IDLE: begin
        if (ar_hs) begin
          arid_d    = i_req.ar.id;
          rcnt_d    = i_req.ar.len;
          r_state_d = R_BEAT;
        end
      end
      R_BEAT: begin
        if (r_hs) begin
          if (rcnt_q == 8'd0) r_state_d = R_IDLE;
          else                rcnt_d    = rcnt_q - 8'd1;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_BEAT);
    rlast_d   = (r_state_d == R_BEAT) && (rcnt_d == 8'd0);
  end

  // Read FSM registers.
  always_ff @(posedge i_clk or negedge ni_rst) begin
    if (!ni_rst) begin
      r_state_q <= R_IDLE;
      arid_q    <= '0;
      rcnt_q    <= 8'd0;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      arid_q    <= arid_d;
      rcnt_q    <= rcnt_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rlast_q   <= rlast_d;
    end
  end

  // Pack the registered channel state onto the response bus.
  always_comb begin
    o_resp          = '0;
    o_resp.aw_ready = awready_q;
    o_resp.w_ready  = wready_q;
    o_resp.ar_ready = arready_q;
    o_resp.b.id     = aw_q.id;
    o_resp.b.resp   = bresp_q;
    o_resp.b_valid  = bvalid_q;
    o_resp.r.id     = arid_q;
    o_resp.r.data   = '0;
    o_resp.r.resp   = RESP_OKAY;
    o_resp.r.last   = rlast_q;
    o_resp.r_valid  = rvalid_q;
  end

  assign o_setipnum_valid = sip_valid_q;
  assign o_setipnum_imsic = sip_imsic_q;
  assign o_setipnum_file  = sip_file_q;
  assign o_setipnum_eiid  = sip_eiid_q;

endmodule

// File: tb/tb_imsic_msi_rx.sv
// Directed bench for imsic_msi_rx: cycle-accurate write/read transactions,
// error targets, back-pressure and reset during a pending notify.
module tb_imsic_msi_rx;
  import imsic_msi_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       sip_valid;
  logic       sip_ready;
  logic [1:0] sip_imsic;
  logic [1:0] sip_file;
  logic [5:0] sip_eiid;
  int         n_chk;
  int         n_pass;

  imsic_msi_rx_if axi();

  imsic_msi_rx dut (
    .i_clk            (clk),
    .ni_rst           (rst_n),
    .i_req            (axi.req),
    .o_resp           (axi.rsp),
    .o_setipnum_valid (sip_valid),
    .i_setipnum_ready (sip_ready),
    .o_setipnum_imsic (sip_imsic),
    .o_setipnum_file  (sip_file),
    .o_setipnum_eiid  (sip_eiid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
  endtask

  // Issue one write starting at a negedge; AW and W are presented together.
  task automatic axi_write(input string name, input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [2:0] size, input logic [63:0] data,
                           input int nbeats, input int hold, input int exp_vcnt,
                           input logic [1:0] exp_imsic, input logic [1:0] exp_file,
                           input logic [5:0] exp_eiid, input int exp_bcyc,
                           input logic [1:0] exp_resp);
    int cyc, vcnt, first_v, b_cyc, wbeats, left;
    logic aw_hs, w_hs;
    logic [1:0] b_resp;
    logic [3:0] b_id;
    cyc = 0; vcnt = 0; first_v = -1; b_cyc = -1; wbeats = 0; left = nbeats;
    b_resp = 2'b11; b_id = 4'h0;
    axi.req.aw.addr  = addr;
    axi.req.aw.id    = id;
    axi.req.aw.len   = len;
    axi.req.aw.size  = size;
    axi.req.aw_valid = 1'b1;
    axi.req.w.data   = data;
    axi.req.w.last   = (nbeats == 1);
    axi.req.w_valid  = 1'b1;
    axi.req.b_ready  = 1'b1;
    sip_ready        = 1'b0;
    while (b_cyc < 0 && cyc < 40) begin
      if (sip_valid) begin
        vcnt++;
        if (first_v < 0) first_v = cyc;
        check_eq({name, ".imsic"}, 64'(sip_imsic), 64'(exp_imsic));
        check_eq({name, ".file"}, 64'(sip_file), 64'(exp_file));
        check_eq({name, ".eiid"}, 64'(sip_eiid), 64'(exp_eiid));
      end
      sip_ready = sip_valid && (vcnt > hold);
      if (axi.rsp.b_valid) begin
        b_cyc  = cyc;
        b_resp = axi.rsp.b.resp;
        b_id   = axi.rsp.b.id;
      end
      aw_hs = axi.req.aw_valid && axi.rsp.aw_ready;
      w_hs  = axi.req.w_valid && axi.rsp.w_ready;
      @(negedge clk);
      cyc++;
      if (aw_hs) axi.req.aw_valid = 1'b0;
      if (w_hs) begin
        wbeats++;
        left--;
        axi.req.w_valid = (left > 0);
        axi.req.w.last  = (left == 1);
      end
    end
    sip_ready = 1'b0;
    check_eq({name, ".vcnt"}, 64'(vcnt), 64'(exp_vcnt));
    check_eq({name, ".first_v"}, 64'(first_v), (exp_vcnt > 0) ? 64'(2) : 64'(-1));
    check_eq({name, ".b_cyc"}, 64'(b_cyc), 64'(exp_bcyc));
    check_eq({name, ".bresp"}, 64'(b_resp), 64'(exp_resp));
    check_eq({name, ".bid"}, 64'(b_id), 64'(id));
    check_eq({name, ".wbeats"}, 64'(wbeats), 64'(nbeats));
    check_eq({name, ".idle"}, 64'(axi.rsp.aw_ready), 64'(1));
  endtask

  // Issue one read starting at a negedge; rready held low for the first 'stall' rvalid cycles.
  task automatic axi_read(input string name, input logic [3:0] id, input logic [7:0] len,
                          input int stall);
    int cyc, acc, vcyc, first_r;
    logic ar_hs;
    cyc = 0; acc = 0; vcyc = 0; first_r = -1;
    axi.req.ar.id    = id;
    axi.req.ar.len   = len;
    axi.req.ar_valid = 1'b1;
    axi.req.r_ready  = 1'b0;
    while (acc < int'(len) + 1 && cyc < 40) begin
      if (axi.rsp.r_valid) begin
        vcyc++;
        if (first_r < 0) first_r = cyc;
        axi.req.r_ready = (vcyc > stall);
        if (axi.req.r_ready) begin
          acc++;
          check_eq({name, ".rdata"}, axi.rsp.r.data, 64'(0));
          check_eq({name, ".rlast"}, 64'(axi.rsp.r.last), 64'(acc == int'(len) + 1));
          check_eq({name, ".rid"}, 64'(axi.rsp.r.id), 64'(id));
          check_eq({name, ".rresp"}, 64'(axi.rsp.r.resp), 64'(RESP_OKAY));
        end
      end else begin
        axi.req.r_ready = 1'b0;
      end
      ar_hs = axi.req.ar_valid && axi.rsp.ar_ready;
      @(negedge clk);
      cyc++;
      if (ar_hs) axi.req.ar_valid = 1'b0;
    end
    axi.req.r_ready = 1'b0;
    check_eq({name, ".first_r"}, 64'(first_r), 64'(1));
    check_eq({name, ".beats"}, 64'(acc), 64'(int'(len) + 1));
    check_eq({name, ".vcyc"}, 64'(vcyc), 64'(int'(len) + 1 + stall));
    check_eq({name, ".rdone"}, 64'(axi.rsp.r_valid), 64'(0));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic aw_hs, w_hs;
    n_chk = 0;
    n_pass = 0;
    axi.req   = '0;
    sip_ready = 1'b0;
    rst_n     = 1'b0;
    repeat (2) @(negedge clk);
    check_eq("rst.awready", 64'(axi.rsp.aw_ready), 64'(0));
    check_eq("rst.arready", 64'(axi.rsp.ar_ready), 64'(0));
    check_eq("rst.wready", 64'(axi.rsp.w_ready), 64'(0));
    check_eq("rst.bvalid", 64'(axi.rsp.b_valid), 64'(0));
    check_eq("rst.rvalid", 64'(axi.rsp.r_valid), 64'(0));
    check_eq("rst.sip", 64'({sip_valid, sip_imsic, sip_file, sip_eiid}), 64'(0));
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("idle.awready", 64'(axi.rsp.aw_ready), 64'(1));
    check_eq("idle.arready", 64'(axi.rsp.ar_ready), 64'(1));

    axi_write("basic", 32'h2400_1000, 4'h3, 8'd0, 3'd2, 64'd5, 1, 0,
              1, 2'd0, 2'd1, 6'd5, 3, RESP_OKAY);
    axi_write("bp_max", 32'h2400_6000, 4'hA, 8'd0, 3'd2, {32'h0000_0011, 32'd63}, 1, 5,
              6, 2'd1, 2'd2, 6'd63, 8, RESP_OKAY);
    axi_write("drop0", 32'h2400_0000, 4'h1, 8'd0, 3'd2, 64'd0, 1, 0,
              0, 2'd0, 2'd0, 6'd0, 2, RESP_OKAY);
    axi_write("drop64", 32'h2400_C000, 4'h2, 8'd0, 3'd2, 64'd64, 1, 0,
              0, 2'd0, 2'd0, 6'd0, 2, RESP_OKAY);
    axi_write("last_tgt", 32'h2400_E000, 4'h4, 8'd0, 3'd2, 64'd1, 1, 0,
              1, 2'd3, 2'd2, 6'd1, 3, RESP_OKAY);
    axi_write("imsic4", 32'h2401_0000, 4'h5, 8'd0, 3'd2, 64'd5, 1, 0,
              0, 2'd0, 2'd0, 6'd0, 2, RESP_SLVERR);
    axi_write("file3", 32'h2400_3000, 4'h6, 8'd0, 3'd2, 64'd5, 1, 0,
              0, 2'd0, 2'd0, 6'd0, 2, RESP_SLVERR);
    axi_write("below", 32'h23FF_F000, 4'h7, 8'd0, 3'd2, 64'd5, 1, 0,
              0, 2'd0, 2'd0, 6'd0, 2, RESP_SLVERR);
    axi_write("size3", 32'h2400_1000, 4'h8, 8'd0, 3'd3, 64'd5, 1, 0,
              0, 2'd0, 2'd0, 6'd0, 2, RESP_SLVERR);
    axi_write("burst", 32'h2400_1000, 4'hB, 8'd3, 3'd2, 64'd5, 4, 0,
              0, 2'd0, 2'd0, 6'd0, 5, RESP_SLVERR);
`ifdef MSI_BE_EN
    axi_write("be_off", 32'h2400_0004, 4'hC, 8'd0, 3'd2, {32'h0700_0000, 32'h0}, 1, 0,
              1, 2'd0, 2'd0, 6'd7, 3, RESP_OKAY);
`else
    axi_write("be_off", 32'h2400_0004, 4'hC, 8'd0, 3'd2, {32'h0700_0000, 32'h0}, 1, 0,
              0, 2'd0, 2'd0, 6'd0, 2, RESP_SLVERR);
`endif

    fork
      axi_write("conc_w", 32'h2400_8000, 4'hD, 8'd0, 3'd2, 64'd33, 1, 0,
                1, 2'd2, 2'd0, 6'd33, 3, RESP_OKAY);
      axi_read("conc_r", 4'h5, 8'd2, 0);
    join
    axi_read("rd_stall", 4'h9, 8'd0, 2);

    // Reset while a set-pending request is held by a stalled IMSIC.
    axi.req.aw.addr  = 32'h2400_1000;
    axi.req.aw.id    = 4'h9;
    axi.req.aw.len   = 8'd0;
    axi.req.aw.size  = 3'd2;
    axi.req.aw_valid = 1'b1;
    axi.req.w.data   = 64'd9;
    axi.req.w.last   = 1'b1;
    axi.req.w_valid  = 1'b1;
    axi.req.b_ready  = 1'b1;
    sip_ready        = 1'b0;
    cyc = 0;
    while (!sip_valid && cyc < 10) begin
      aw_hs = axi.req.aw_valid && axi.rsp.aw_ready;
      w_hs  = axi.req.w_valid && axi.rsp.w_ready;
      @(negedge clk);
      cyc++;
      if (aw_hs) axi.req.aw_valid = 1'b0;
      if (w_hs) axi.req.w_valid = 1'b0;
    end
    check_eq("rstmid.pending", 64'(sip_valid), 64'(1));
    rst_n = 1'b0;
    #1;
    check_eq("rstmid.sip", 64'({sip_valid, sip_imsic, sip_file, sip_eiid}), 64'(0));
    check_eq("rstmid.bvalid", 64'(axi.rsp.b_valid), 64'(0));
    check_eq("rstmid.ready", 64'({axi.rsp.aw_ready, axi.rsp.w_ready, axi.rsp.ar_ready}), 64'(0));
    axi.req = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    axi_write("post_rst", 32'h2400_5000, 4'h6, 8'd0, 3'd2, 64'd12, 1, 0,
              1, 2'd1, 2'd1, 6'd12, 3, RESP_OKAY);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
